// File: rtl/rs_encoder_lfsr.sv
// rs_encoder_lfsr: systematic RS(7,5) encoder over GF(8), p(x) = x^3 + x + 1.
// Five index-form message symbols are shifted MSB-symbol first through a
// 2-stage LFSR with g(x) = x^2 + a^4*x + a^3. The two parity symbols are then
// appended to form the 21-bit codeword.
// Optional build macro: RS_ENC_ERR_INJECT_EN adds an error-injection port set.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a message, in_ready = 1
// SHIFT | clocking message symbols through the LFSR (cnt 0..4)
// DONE  | codeword valid and held until out_ready
module rs_encoder_lfsr #(
    parameter int SYM_W  = 3,
    parameter int G1_IDX = 5,
    parameter int G0_IDX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5*SYM_W-1:0]   message,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7*SYM_W-1:0]   codeword
`ifdef RS_ENC_ERR_INJECT_EN
    ,
    input  logic                 inj_en,
    input  logic [2:0]           inj_pos,
    input  logic [2:0]           inj_val
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Index form k -> polynomial form; bit 2 holds the x^0 coefficient.
    function automatic logic [2:0] idx2poly(input logic [2:0] i);
        case (i)
            3'd1:    return 3'b100;
            3'd2:    return 3'b010;
            3'd3:    return 3'b001;
            3'd4:    return 3'b110;
            3'd5:    return 3'b011;
            3'd6:    return 3'b111;
            3'd7:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] poly2idx(input logic [2:0] p);
        case (p)
            3'b100:  return 3'd1;
            3'b010:  return 3'd2;
            3'b001:  return 3'd3;
            3'b110:  return 3'd4;
            3'b011:  return 3'd5;
            3'b111:  return 3'd6;
            3'b101:  return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // GF(8) multiply of polynomial-form operands via exponent addition mod 7.
    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] ia;
        logic [2:0] ib;
        logic [3:0] e;
        ia = poly2idx(a);
        ib = poly2idx(b);
        if (ia == 3'd0 || ib == 3'd0) return 3'b000;
        e = {1'b0, ia} + {1'b0, ib} - 4'd2;
        if (e >= 4'd7) e = e - 4'd7;
        return idx2poly(e[2:0] + 3'd1);
    endfunction

    localparam logic [2:0] G1_P = idx2poly(3'(G1_IDX));
    localparam logic [2:0] G0_P = idx2poly(3'(G0_IDX));

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [5*SYM_W-1:0]   msg_q, msg_d;
    logic [2:0]           r1_q, r1_d, r0_q, r0_d;
    logic                 out_valid_q, out_valid_d;
    logic [7*SYM_W-1:0]   codeword_q, codeword_d;
`ifdef RS_ENC_ERR_INJECT_EN
    logic                 inj_en_q, inj_en_d;
    logic [2:0]           inj_pos_q, inj_pos_d;
    logic [2:0]           inj_val_q, inj_val_d;
`endif

    logic [2:0]           sym;
    logic [2:0]           fb;
    logic [2:0]           r1_n, r0_n;
    logic [7*SYM_W-1:0]   cw_new;

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = out_valid_q;
    assign codeword  = codeword_q;

    // Next-state, LFSR step and codeword assembly.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_d       = msg_q;
        r1_d        = r1_q;
        r0_d        = r0_q;
        out_valid_d = out_valid_q;
        codeword_d  = codeword_q;
`ifdef RS_ENC_ERR_INJECT_EN
        inj_en_d    = inj_en_q;
        inj_pos_d   = inj_pos_q;
        inj_val_d   = inj_val_q;
`endif

        case (cnt_q)
            3'd0:    sym = msg_q[14:12];
            3'd1:    sym = msg_q[11:9];
            3'd2:    sym = msg_q[8:6];
            3'd3:    sym = msg_q[5:3];
            default: sym = msg_q[2:0];
        endcase
        fb   = idx2poly(sym) ^ r1_q;
        r1_n = r0_q ^ gf_mul(G1_P, fb);
        r0_n = gf_mul(G0_P, fb);

        cw_new = {msg_q, poly2idx(r1_n), poly2idx(r0_n)};
`ifdef RS_ENC_ERR_INJECT_EN
        if (inj_en_q && inj_val_q != 3'd0) begin
            for (int i = 0; i < 7; i++) begin
                if (inj_pos_q == 3'(i))
                    cw_new[3*i +: 3] = poly2idx(idx2poly(cw_new[3*i +: 3]) ^ idx2poly(inj_val_q));
            end
        end
`endif

        case (state_q)
            SHIFT: begin
                r1_d  = r1_n;
                r0_d  = r0_n;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    cnt_d       = 3'd0;
                    codeword_d  = cw_new;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        // Accept covers both IDLE and the DONE back-to-back handoff.
        if (in_valid && in_ready) begin
            msg_d   = message;
            r1_d    = 3'b000;
            r0_d    = 3'b000;
            cnt_d   = 3'd0;
            state_d = SHIFT;
`ifdef RS_ENC_ERR_INJECT_EN
            inj_en_d  = inj_en;
            inj_pos_d = inj_pos;
            inj_val_d = inj_val;
`endif
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            msg_q       <= '0;
            r1_q        <= '0;
            r0_q        <= '0;
            out_valid_q <= 1'b0;
            codeword_q  <= '0;
`ifdef RS_ENC_ERR_INJECT_EN
            inj_en_q    <= 1'b0;
            inj_pos_q   <= '0;
            inj_val_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            msg_q       <= msg_d;
            r1_q        <= r1_d;
            r0_q        <= r0_d;
            out_valid_q <= out_valid_d;
            codeword_q  <= codeword_d;
`ifdef RS_ENC_ERR_INJECT_EN
            inj_en_q    <= inj_en_d;
            inj_pos_q   <= inj_pos_d;
            inj_val_q   <= inj_val_d;
`endif
        end
    end

endmodule
